seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display. One hex-to-seven-segment decoder is shared across all digits. The block double-buffers the displayed value, cycles through the digits with a blanking gap between them to prevent ghosting, and can suppress leading zeros. It sits between the register/bus logic that produces display data and the board-level anode and segment pins.

Parameters:
NDIGITS, 4, number of digits scanned (≥2)
DIV, 50000, clock cycles per digit slot, blanking gap included (≥2)
GAP, 500, blanking cycles at the start of each slot (1 ≤ GAP < DIV)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  scan enable
load  input  1  one-cycle strobe; captures data_in into the pending buffer
data_in  input  4*NDIGITS  nibble i = digit i; digit 0 is rightmost/least significant
dp_in  input  NDIGITS  decimal point per digit, sampled together with data_in
lz_en  input  1  leading-zero suppression enable (read live, not buffered)
an  output  NDIGITS  anode enables, active-low, one-hot-low while driving
seg  output  7  segments {a,b,c,d,e,f,g} on seg[6:0], active-high
dp  output  1  decimal point, active-high
frame_done  output  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: an = all ones, seg = 0, dp = 0, frame_done = 0. pending, shadow, slot counter, digit index and the pending-valid flag all clear to 0. State = S_IDLE.
- All outputs are registered.
- Slot counter width is $clog2(DIV). Index width is $clog2(NDIGITS).

FSM:
- S_IDLE
  - an = all ones, seg = 0, dp = 0.
  - When en=1: transfer pending to shadow if pending-valid is set, then go to S_BLANK with idx = 0 and cnt = 0.
- S_BLANK
  - an = all ones, seg = 0, dp = 0.
  - Lasts GAP cycles (cnt 0..GAP-1). Then go to S_DRIVE.
- S_DRIVE
  - an[idx] = 0, others 1.
  - seg = decode(shadow nibble idx). dp = shadow_dp[idx].
  - Lasts DIV-GAP cycles (cnt GAP..DIV-1). Then idx increments and the FSM returns to S_BLANK.
  - On wrap idx = NDIGITS-1 → 0:
    - frame_done = 1 for exactly one cycle (the first cycle of the new S_BLANK).
    - Pending transfers to shadow if pending-valid is set.
- en=0 in any state: S_IDLE on the next edge. Outputs are blank on that edge. idx and cnt reset to 0. No frame_done pulse.
- Each full frame is NDIGITS*DIV cycles.
- Load:
  - load=1 captures data_in and dp_in into pending and sets pending-valid.
  - shadow never changes mid-frame.
  - If load coincides with a frame boundary, the new data_in/dp_in go directly to shadow (bypass) and pending-valid is cleared.
  - Back-to-back loads within one frame: last one wins.
- Leading-zero suppression (lz_en=1):
  - Digit i ≥ 1 is suppressed if shadow nibbles i..NDIGITS-1 are all zero.
  - A suppressed digit's DRIVE slot behaves like blank: an all ones, seg = 0, dp = 0. Slot timing is unchanged.
  - Digit 0 is never suppressed.
  - A set dp on a suppressed digit does not un-suppress it.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). Pending data is lost.

Decomposition:
- Package seg7_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t
  - localparam logic [6:0] SEG_BLANK = 7'b0000000
  - 16-entry hex segment constant table (0 = 7'b1111110, 1 = 7'b0110000, 2 = 7'b1101101, 5 = 7'b1011011, A = 7'b1110111, F = 7'b1000111, rest standard)
- Sub-module seg7_hex_dec: combinational 4-bit → 7-bit lookup using the package table, instantiated once. Its output is gated/registered by seg7_scan_ctrl.

Test Plan:
(NDIGITS=4, DIV=8, GAP=2)
- Reset: reset_n=0 asynchronously mid-S_DRIVE → same timestep an=4'b1111, seg=0, dp=0, frame_done=0. After release with en=1 → digit 0 shows 7'b1111110, slot-0 DRIVE starts 2 cycles after entering S_BLANK.
- Basic scan: load 16'h12AF with en=1 from idle → repeating 8-cycle slots, each 2 cycles an=1111 then 6 cycles driven:
  - an=1110/seg=1000111
  - an=1101/seg=1110111
  - an=1011/seg=1101101
  - an=0111/seg=0110000
  - frame_done pulses every 32 cycles.
- Double buffering: shadow=16'h1111, then load 16'h2222 during the digit-1 slot → remaining slots of this frame show seg=0110000. After frame_done, all digits show 1101101.
- Leading zeros: lz_en=1, data 16'h0050 → slots 3 and 2 have an=1111 for all 8 cycles, digit 1 shows 1011011, digit 0 shows 1111110. With lz_en=0, digits 3 and 2 show 1111110.
- Load coincident with frame boundary: load 16'hF000 in the same cycle as the wrap → digit 0 in the new frame shows 1111110, digit 3 shows 1000111, and pending-valid is clear afterwards.
- Enable drop: en=0 during the digit-2 DRIVE → next edge an=1111, seg=0, no frame_done pulse. en=1 again → scan restarts at digit 0 after 2 blank cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment table for the seven-segment scan controller
package seg7_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment patterns {a,b,c,d,e,f,g}, active-high; entry i is hex digit i
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// rtl/seg7_hex_dec.sv - combinational hex nibble to seven-segment lookup
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - double-buffered multiplexed scan controller for a common-anode display
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000,
    parameter int GAP     = 500
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   data_in,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   lz_en,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic                   frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NDIGITS);

    localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NDIGITS - 1);

    scan_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;

    logic [4*NDIGITS-1:0] pending, shadow;
    logic [NDIGITS-1:0]   pending_dp, shadow_dp;
    logic                 pending_valid;

    logic [NDIGITS-1:0]   an_next;
    logic [6:0]           seg_next;
    logic                 dp_next;
    logic                 frame_done_next;

    logic                 wrap;
    logic                 xfer;
    logic [3:0]           cur_nibble;
    logic [6:0]           dec_seg;
    logic                 upper_zero;
    logic                 suppress;

    // End of the last digit's drive slot closes the frame
    assign wrap = (state == S_DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Shadow may only change when a frame starts: leaving idle or at the wrap
    assign xfer = en && ((state == S_IDLE) || wrap);

    // Shadow is stable on any edge entering S_DRIVE, so decode the upcoming digit directly
    assign cur_nibble = shadow[idx_next*4 +: 4];
    assign upper_zero = ((shadow >> (idx_next*4)) == '0);
    assign suppress   = lz_en && (idx_next != '0) && upper_zero;

    seg7_hex_dec u_hex_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // State, slot counter and digit index register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Slot sequencing: GAP blank cycles then DIV-GAP drive cycles per digit
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        if (!en) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                S_BLANK: begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNT_GAP_LAST) begin
                        state_next = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state_next = S_BLANK;
                        cnt_next   = '0;
                        idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so the registered pins line up with the state
    always_comb begin
        an_next         = '1;
        seg_next        = SEG_BLANK;
        dp_next         = 1'b0;
        frame_done_next = wrap && en;
        if ((state_next == S_DRIVE) && !suppress) begin
            an_next[idx_next] = 1'b0;
            seg_next          = dec_seg;
            dp_next           = shadow_dp[idx_next];
        end
    end

    // Output pin registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= frame_done_next;
        end
    end

    // Pending/shadow double buffer; a load at a frame start bypasses straight to shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending       <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            shadow        <= '0;
            shadow_dp     <= '0;
        end else begin
            if (xfer && load) begin
                shadow        <= data_in;
                shadow_dp     <= dp_in;
                pending_valid <= 1'b0;
            end else if (xfer && pending_valid) begin
                shadow        <= pending;
                shadow_dp     <= pending_dp;
                pending_valid <= 1'b0;
            end else if (load) begin
                pending_valid <= 1'b1;
            end
            if (load) begin
                pending    <= data_in;
                pending_dp <= dp_in;
            end
        end
    end

endmodule
